// File: rtl/rmst_trans_arbiter_pkg.sv
// Shared types and elaboration helpers for the read-master transaction arbiter.
// The state encoding is fixed so that it reads the same in waveform dumps across the project.
package rmst_trans_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE  = 2'b00,
    ARB_ISSUE = 2'b01,
    ARB_WAIT  = 2'b10
  } arb_state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

  function automatic bit params_legal(input int nr, input int gw);
    return (nr >= 2) && (nr <= 4) && (gw >= clog2(nr));
  endfunction

endpackage

// File: rtl/rmst_trans_arbiter_rr_pick.sv
// Combinational rotating-priority encoder: first pending requester after last_grant, with wrap-around.
module rr_pick
  import rmst_trans_arbiter_pkg::*;
#(
  parameter int NR = 3,
  parameter int GW = 2
) (
  input  logic [NR-1:0] pending,
  input  logic [GW-1:0] last_grant,
  output logic          any,
  output logic [GW-1:0] winner
);

  logic found;

  // The outer loop walks the priority order; the inner loop keeps every bit select constant.
  always_comb begin
    any    = |pending;
    winner = '0;
    found  = 1'b0;
    for (int k = 1; k <= NR; k++) begin
      for (int j = 0; j < NR; j++) begin
        if (!found && (j == ((int'(last_grant) + k) % NR)) && pending[j]) begin
          winner = GW'(j);
          found  = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/rmst_trans_arbiter.sv
// Shares one Avalon read-master transaction engine between NR load controllers,
// queuing 1-cycle requests and granting them round-robin.
module rmst_trans_arbiter
  import rmst_trans_arbiter_pkg::*;
#(
  parameter int NR = 3,
  parameter int GW = 2,
  parameter int DW = 32,
  parameter int AW = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NR-1:0]    req_trans_start,
  input  logic [NR*DW-1:0] req_raddr,
  input  logic [NR*AW-1:0] req_iolen,
  output logic [NR-1:0]    req_trans_done,
  output logic             mst_trans_start,
  output logic [DW-1:0]    mst_raddr,
  output logic [AW-1:0]    mst_iolen,
  input  logic             mst_trans_done,
  output logic [GW-1:0]    grant_id,
  output logic             busy,
  output logic             proto_err
);

  if (!params_legal(NR, GW)) begin : g_param_err
    $error("rmst_trans_arbiter: NR must be 2..4 and GW >= clog2(NR)");
  end

  arb_state_t    state;
  logic [NR-1:0] pending;
  logic [GW-1:0] last_grant;
  logic          any;
  logic [GW-1:0] winner;
  logic          done_fire;
  logic [NR-1:0] done_vec;
  logic [DW-1:0] win_addr;
  logic [AW-1:0] win_len;
  logic          dup_start;
  logic          stray_done;

  rr_pick #(.NR(NR), .GW(GW)) u_pick (
    .pending    (pending),
    .last_grant (last_grant),
    .any        (any),
    .winner     (winner)
  );

  assign done_fire  = (state == ARB_WAIT) && mst_trans_done;
  assign stray_done = mst_trans_done && (state != ARB_WAIT);
  // A re-request landing on the very edge that retires the same requester is legal, not a duplicate.
  assign dup_start  = |(req_trans_start & pending & ~done_vec);

  always_comb begin
    done_vec = '0;
    win_addr = '0;
    win_len  = '0;
    for (int i = 0; i < NR; i++) begin
      if (grant_id == GW'(i)) done_vec[i] = done_fire;
      if (winner == GW'(i)) begin
        win_addr = req_raddr[i*DW +: DW];
        win_len  = req_iolen[i*AW +: AW];
      end
    end
  end

  // Set has priority over clear so a same-edge re-request is never lost.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) pending <= '0;
    else     pending <= (pending & ~done_vec) | req_trans_start;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                          proto_err <= 1'b0;
    else if (dup_start || stray_done) proto_err <= 1'b1;
  end

  // Grants wait while req_trans_done is still high, so the finished requester
  // sees its completion before the shared master is handed to anyone else.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= ARB_IDLE;
      last_grant      <= GW'(NR - 1);
      grant_id        <= '0;
      mst_raddr       <= '0;
      mst_iolen       <= '0;
      mst_trans_start <= 1'b0;
      busy            <= 1'b0;
      req_trans_done  <= '0;
    end else begin
      req_trans_done  <= done_vec;
      mst_trans_start <= 1'b0;
      unique case (state)
        ARB_IDLE: begin
          if (any && (req_trans_done == '0)) begin
            state           <= ARB_ISSUE;
            grant_id        <= winner;
            last_grant      <= winner;
            mst_raddr       <= win_addr;
            mst_iolen       <= win_len;
            mst_trans_start <= 1'b1;
            busy            <= 1'b1;
          end
        end
        ARB_ISSUE: state <= ARB_WAIT;
        ARB_WAIT: begin
          if (mst_trans_done) begin
            state <= ARB_IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= ARB_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rmst_trans_arbiter.sv
// Directed and randomized checks of rmst_trans_arbiter against a transaction-level round-robin model.
module tb_rmst_trans_arbiter;

  localparam int NR = 3;
  localparam int GW = 2;
  localparam int DW = 32;
  localparam int AW = 12;

  logic             clk = 1'b0;
  logic             rst;
  logic [NR-1:0]    req_trans_start;
  logic [NR*DW-1:0] req_raddr;
  logic [NR*AW-1:0] req_iolen;
  logic [NR-1:0]    req_trans_done;
  logic             mst_trans_start;
  logic [DW-1:0]    mst_raddr;
  logic [AW-1:0]    mst_iolen;
  logic             mst_trans_done;
  logic [GW-1:0]    grant_id;
  logic             busy;
  logic             proto_err;

  int n_asserts = 0;
  int n_fails   = 0;
  int cycle     = 0;

  bit            model_pend [NR];
  int            model_last;
  logic [DW-1:0] model_addr [NR];
  logic [AW-1:0] model_len  [NR];

  always #5 clk = ~clk;

  rmst_trans_arbiter #(.NR(NR), .GW(GW), .DW(DW), .AW(AW)) dut (
    .clk             (clk),
    .rst             (rst),
    .req_trans_start (req_trans_start),
    .req_raddr       (req_raddr),
    .req_iolen       (req_iolen),
    .req_trans_done  (req_trans_done),
    .mst_trans_start (mst_trans_start),
    .mst_raddr       (mst_raddr),
    .mst_iolen       (mst_iolen),
    .mst_trans_done  (mst_trans_done),
    .grant_id        (grant_id),
    .busy            (busy),
    .proto_err       (proto_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    cycle++;
  endtask

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NR-1:0] onehot(input int i);
    logic [NR-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic logic [NR-1:0] pend_mask();
    logic [NR-1:0] m;
    for (int i = 0; i < NR; i++) m[i] = model_pend[i];
    return m;
  endfunction

  // Round-robin rule: first pending requester after the last grant, wrapping modulo NR.
  function automatic int model_pick();
    for (int k = 1; k <= NR; k++) begin
      if (model_pend[(model_last + k) % NR]) return (model_last + k) % NR;
    end
    return 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NR; i++) model_pend[i] = 1'b0;
    model_last = NR - 1;
  endtask

  task automatic set_req(input int i, input logic [DW-1:0] addr, input logic [AW-1:0] len);
    req_raddr[i*DW +: DW] = addr;
    req_iolen[i*AW +: AW] = len;
    model_addr[i] = addr;
    model_len[i]  = len;
  endtask

  task automatic apply_pulse(input logic [NR-1:0] mask, output int t);
    t = cycle;
    req_trans_start = mask;
    tick();
    req_trans_start = '0;
    for (int i = 0; i < NR; i++) if (mask[i]) model_pend[i] = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    model_reset();
  endtask

  task automatic wait_start(input string tag, input int exp_id, output int s);
    bit seen;
    seen = 1'b0;
    s    = -1;
    for (int n = 0; n < 40 && !seen; n++) begin
      if (mst_trans_start === 1'b1) seen = 1'b1;
      else tick();
    end
    check_output({tag, "_start_seen"}, 64'(seen), 64'(1));
    if (seen) begin
      s = cycle;
      check_output({tag, "_grant_id"}, 64'(grant_id), 64'(exp_id));
      check_output({tag, "_raddr"}, 64'(mst_raddr), 64'(model_addr[exp_id]));
      check_output({tag, "_iolen"}, 64'(mst_iolen), 64'(model_len[exp_id]));
      check_output({tag, "_busy"}, 64'(busy), 64'(1));
      model_last = exp_id;
      tick();
      check_output({tag, "_start_one_cycle"}, 64'(mst_trans_start), 64'(0));
    end
  endtask

  task automatic finish_txn(input string tag, input int id, input logic [NR-1:0] collide, output int d);
    d = cycle;
    mst_trans_done  = 1'b1;
    req_trans_start = collide;
    tick();
    mst_trans_done  = 1'b0;
    req_trans_start = '0;
    model_pend[id]  = 1'b0;
    for (int i = 0; i < NR; i++) if (collide[i]) model_pend[i] = 1'b1;
    check_output({tag, "_done_vec"}, 64'(req_trans_done), 64'(onehot(id)));
  endtask

  task automatic count_starts(input string tag, input int cycles);
    int starts;
    starts = 0;
    for (int n = 0; n < cycles; n++) begin
      tick();
      if (mst_trans_start === 1'b1) starts++;
    end
    check_output(tag, 64'(starts), 64'(0));
  endtask

  initial begin
    int t, s, d, w, waits;
    logic [NR-1:0] m;

    rst             = 1'b1;
    req_trans_start = '0;
    req_raddr       = '0;
    req_iolen       = '0;
    mst_trans_done  = 1'b0;
    model_reset();
    tick();
    tick();
    check_output("rst_done", 64'(req_trans_done), 64'(0));
    check_output("rst_start", 64'(mst_trans_start), 64'(0));
    check_output("rst_raddr", 64'(mst_raddr), 64'(0));
    check_output("rst_iolen", 64'(mst_iolen), 64'(0));
    check_output("rst_grant", 64'(grant_id), 64'(0));
    check_output("rst_busy", 64'(busy), 64'(0));
    check_output("rst_err", 64'(proto_err), 64'(0));
    rst = 1'b0;
    tick();

    $display("[TB] single request");
    set_req(0, 32'h0008_0000, 12'd144);
    apply_pulse(3'b001, t);
    wait_start("t1", 0, s);
    check_output("t1_latency", 64'(s - t), 64'(2));
    tick();
    tick();
    check_output("t1_busy_wait", 64'(busy), 64'(1));
    finish_txn("t1", 0, '0, d);
    check_output("t1_idle_after", 64'(busy), 64'(0));

    $display("[TB] simultaneous requests");
    do_reset();
    set_req(0, 32'h1000_0000, 12'd16);
    set_req(1, 32'h2000_0040, 12'd32);
    set_req(2, 32'h3000_0080, 12'd48);
    apply_pulse(3'b111, t);
    for (int k = 0; k < NR; k++) begin
      wait_start($sformatf("t2_%0d", k), k, s);
      if (k > 0) check_output($sformatf("t2_gap_%0d", k), 64'((s - d) >= 3), 64'(1));
      finish_txn($sformatf("t2_%0d", k), k, '0, d);
    end

    $display("[TB] fairness");
    apply_pulse(3'b011, t);
    for (int k = 0; k < 5; k++) begin
      w = k % 2;
      wait_start($sformatf("t3_%0d", k), w, s);
      finish_txn($sformatf("t3_%0d", k), w, '0, d);
      if (k < 3) apply_pulse(onehot(w), t);
    end

    $display("[TB] set/clear collision");
    set_req(2, 32'h4000_0100, 12'd200);
    apply_pulse(3'b100, t);
    wait_start("t5_a", 2, s);
    finish_txn("t5_a", 2, 3'b100, d);
    check_output("t5_no_err", 64'(proto_err), 64'(0));
    wait_start("t5_b", 2, s);
    check_output("t5_gap", 64'((s - d) >= 3), 64'(1));
    finish_txn("t5_b", 2, '0, d);
    count_starts("t5_no_third", 6);

    $display("[TB] duplicate request");
    set_req(1, 32'h5000_0200, 12'd7);
    apply_pulse(3'b010, t);
    apply_pulse(3'b010, s);
    check_output("t4_dup_err", 64'(proto_err), 64'(1));
    wait_start("t4_dup", 1, s);
    check_output("t4_dup_latency", 64'(s - t), 64'(2));
    finish_txn("t4_dup", 1, '0, d);
    count_starts("t4_single_txn", 8);

    $display("[TB] reset mid-transaction");
    set_req(0, 32'h6000_0300, 12'd99);
    apply_pulse(3'b001, t);
    wait_start("t6", 0, s);
    rst = 1'b1;
    tick();
    check_output("t6_done", 64'(req_trans_done), 64'(0));
    check_output("t6_start", 64'(mst_trans_start), 64'(0));
    check_output("t6_raddr", 64'(mst_raddr), 64'(0));
    check_output("t6_iolen", 64'(mst_iolen), 64'(0));
    check_output("t6_grant", 64'(grant_id), 64'(0));
    check_output("t6_busy", 64'(busy), 64'(0));
    check_output("t6_err", 64'(proto_err), 64'(0));
    rst = 1'b0;
    model_reset();
    count_starts("t6_pending_cleared", 6);

    $display("[TB] spurious completion");
    mst_trans_done = 1'b1;
    tick();
    mst_trans_done = 1'b0;
    check_output("t4_spur_err", 64'(proto_err), 64'(1));
    check_output("t4_spur_done", 64'(req_trans_done), 64'(0));
    check_output("t4_spur_busy", 64'(busy), 64'(0));
    tick();
    check_output("t4_spur_done2", 64'(req_trans_done), 64'(0));
    check_output("t4_spur_start", 64'(mst_trans_start), 64'(0));

    set_req(1, 32'h7000_0400, 12'd64);
    apply_pulse(3'b010, t);
    wait_start("t6_post", 1, s);
    check_output("t6_post_latency", 64'(s - t), 64'(2));
    finish_txn("t6_post", 1, '0, d);

    $display("[TB] randomized traffic");
    do_reset();
    for (int n = 0; n < 30; n++) begin
      if (pend_mask() == '0) begin
        m = NR'($urandom_range(1, (1 << NR) - 1));
        for (int i = 0; i < NR; i++)
          if (m[i]) set_req(i, $urandom, AW'($urandom_range(1, (1 << AW) - 1)));
        apply_pulse(m, t);
      end
      w = model_pick();
      wait_start($sformatf("rnd_%0d", n), w, s);
      waits = $urandom_range(0, 3);
      for (int c = 0; c < waits; c++) begin
        m = NR'($urandom_range(0, (1 << NR) - 1)) & ~pend_mask();
        for (int i = 0; i < NR; i++)
          if (m[i]) set_req(i, $urandom, AW'($urandom_range(1, (1 << AW) - 1)));
        apply_pulse(m, t);
      end
      finish_txn($sformatf("rnd_%0d", n), w, '0, d);
    end
    for (int n = 0; n < NR; n++) begin
      if (pend_mask() != '0) begin
        w = model_pick();
        wait_start($sformatf("drain_%0d", n), w, s);
        finish_txn($sformatf("drain_%0d", n), w, '0, d);
      end
    end
    count_starts("rnd_quiet", 6);
    check_output("rnd_no_err", 64'(proto_err), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
    $finish;
  end

endmodule
